// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int unsigned CLA_GROUP = 4;

  // Generate/propagate summary of one 4-bit lookahead group.
  typedef struct packed {
    logic gg;
    logic gp;
  } group_gp_t;

  function automatic int unsigned num_groups(input int unsigned width);
    return width / CLA_GROUP;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: flat carry equations plus group generate/propagate.
module cla_group4 (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       ci,
  output logic [4:1] c,
  output logic       gg,
  output logic       gp
);

  always_comb begin
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    gp = p[3] & p[2] & p[1] & p[0];

    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = gg | (gp & ci);
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready on both sides.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned NumGroups = num_groups(WIDTH);

  if (GROUP != CLA_GROUP || (WIDTH % GROUP) != 0 || WIDTH < 8) begin : g_bad_param
    $error("cla_pipe_adder: WIDTH must be a multiple of 4 and >= 8, GROUP must be 4");
  end

  logic                 s1_valid;
  logic                 s2_valid;
  logic                 s1_adv;
  logic                 s2_adv;
  logic                 in_fire;
  logic [WIDTH-1:0]     s1_g;
  logic [WIDTH-1:0]     s1_p;
  logic                 s1_c0;
  logic [WIDTH:0]       c;
  logic [NumGroups:0]   gc;
  group_gp_t [NumGroups-1:0] grp;

  always_comb begin
    s2_adv   = !s2_valid || out_ready;
    s1_adv   = !s1_valid || s2_adv;
    in_ready = s1_adv;
    in_fire  = in_valid && s1_adv;
  end

  assign out_valid = s2_valid;

  // Stage 1: capture per-bit generate/propagate straight from the gate level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_g     <= '0;
      s1_p     <= '0;
      s1_c0    <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_g     <= a & b;
      s1_p     <= a ^ b;
      s1_c0    <= cin;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Second-level lookahead: each group carry is a flat sum of products over GG/GP.
  always_comb begin
    logic term;
    term  = 1'b0;
    gc    = '0;
    gc[0] = s1_c0;
    for (int unsigned k = 1; k <= NumGroups; k++) begin
      term = s1_c0;
      for (int unsigned m = 0; m < k; m++) begin
        term = term & grp[m].gp;
      end
      gc[k] = term;
      for (int unsigned j = 0; j < k; j++) begin
        term = grp[j].gg;
        for (int unsigned m = j + 1; m < k; m++) begin
          term = term & grp[m].gp;
        end
        gc[k] = gc[k] | term;
      end
    end
  end

  assign c[0] = s1_c0;

  for (genvar k = 0; k < NumGroups; k++) begin : g_grp
    cla_group4 u_grp (
      .g  (s1_g[CLA_GROUP*k +: CLA_GROUP]),
      .p  (s1_p[CLA_GROUP*k +: CLA_GROUP]),
      .ci (gc[k]),
      .c  (c[CLA_GROUP*k+1 +: CLA_GROUP]),
      .gg (grp[k].gg),
      .gp (grp[k].gp)
    );
  end

  // cout comes from the second-level lookahead; the top group's own c4 feeds overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sum      <= s1_p ^ c[WIDTH-1:0];
        cout     <= gc[NumGroups];
        overflow <= c[WIDTH-1] ^ c[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: expected results queued on input transfer.
module tb_cla_pipe_adder;

  localparam int unsigned WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  res_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(WIDTH), .GROUP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic ci);
    logic [WIDTH:0] full;
    res_t r;
    full   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (r.sum[WIDTH-1] != x[WIDTH-1]);
    return r;
  endfunction

  task automatic drive(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
    in_valid = 1'b1;
    a        = x;
    b        = y;
    cin      = ci;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a        = 'x;
    b        = 'x;
    cin      = 1'bx;
  endtask

  // Advance one clock: note transfers at mid-cycle, push/pop the scoreboard.
  task automatic cycle(output logic fi, output logic fo, output res_t got, output res_t exp);
    @(negedge clk);
    fi       = in_valid && in_ready;
    fo       = out_valid && out_ready;
    got.sum  = sum;
    got.cout = cout;
    got.ovf  = overflow;
    exp      = 'x;
    if (fo && sb.size() > 0) exp = sb.pop_front();
    if (fi) sb.push_back(model(a, b, cin));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    idle();
    #3;
    total++;
    if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got v=%b s=%h c=%b o=%b want 0/0000/0/0",
               out_valid, sum, cout, overflow);
    end
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    logic fi, fo;
    res_t got, exp, want;
    want = {16'h0008, 1'b0, 1'b0};
    out_ready = 1'b1;
    drive(16'h0003, 16'h0005, 1'b0);
    cycle(fi, fo, got, exp);
    idle();
    total++;
    if (fi !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_cycle1 got fire=%b out_valid=%b want 1/0", fi, out_valid);
    end
    cycle(fi, fo, got, exp);
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL basic_latency got out_valid=%b want 1", out_valid);
    end
    cycle(fi, fo, got, exp);
    total++;
    if (fo !== 1'b1 || got !== exp || got !== want) begin
      bad++;
      $display("FAIL basic_result got fire=%b %h want %h", fo, got, want);
    end
  endtask

  task automatic test_carry();
    logic fi, fo;
    res_t got, exp;
    logic [WIDTH-1:0] ta[3];
    logic [WIDTH-1:0] tb[3];
    logic             tc[3];
    res_t             want[3];
    int               sent, rcv;
    ta[0] = 16'hFFFF; tb[0] = 16'h0001; tc[0] = 1'b0; want[0] = {16'h0000, 1'b1, 1'b0};
    ta[1] = 16'h7FFF; tb[1] = 16'h0001; tc[1] = 1'b0; want[1] = {16'h8000, 1'b0, 1'b1};
    ta[2] = 16'h8000; tb[2] = 16'h8000; tc[2] = 1'b1; want[2] = {16'h0001, 1'b1, 1'b1};
    sent = 0;
    rcv  = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12 && rcv < 3; cyc++) begin
      if (sent < 3) drive(ta[sent], tb[sent], tc[sent]);
      else idle();
      cycle(fi, fo, got, exp);
      if (fi) sent++;
      if (fo) begin
        total++;
        if (got !== exp || got !== want[rcv]) begin
          bad++;
          $display("FAIL carry_%0d got %h want %h", rcv, got, want[rcv]);
        end
        rcv++;
      end
    end
    idle();
    total++;
    if (rcv != 3) begin
      bad++;
      $display("FAIL carry_timeout got %0d results want 3", rcv);
    end
  endtask

  task automatic test_backpressure();
    logic fi, fo;
    res_t got, exp, first;
    logic [WIDTH-1:0] pa[5];
    logic [WIDTH-1:0] pb[5];
    int idx;
    for (int i = 0; i < 5; i++) begin
      pa[i] = WIDTH'(16'h1111 * (i + 1));
      pb[i] = WIDTH'(16'h0F0F + i);
    end
    first = model(pa[0], pb[0], 1'b0);
    idx = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      drive(pa[idx], pb[idx], 1'b0);
      cycle(fi, fo, got, exp);
      if (fi) idx++;
      if (cyc >= 1) begin
        total++;
        if (out_valid !== 1'b1 || sum !== first.sum) begin
          bad++;
          $display("FAIL bp_hold cyc%0d got v=%b sum=%h want 1/%h", cyc, out_valid, sum,
                   first.sum);
        end
      end
    end
    total++;
    if (idx != 2 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_stall got accepts=%0d in_ready=%b want 2/0", idx, in_ready);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (idx < 5) drive(pa[idx], pb[idx], 1'b0);
      else idle();
      cycle(fi, fo, got, exp);
      if (fi) idx++;
      total++;
      if (fo !== 1'b1 || got !== exp) begin
        bad++;
        $display("FAIL bp_drain cyc%0d got fire=%b %h want 1 %h", cyc, fo, got, exp);
      end
    end
    idle();
    total++;
    if (idx != 5 || sb.size() != 0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_count got sent=%0d pending=%0d out_valid=%b want 5/0/0", idx,
               sb.size(), out_valid);
    end
  endtask

  task automatic test_simultaneous();
    logic fi, fo;
    res_t got, exp;
    int accepts;
    accepts   = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 6 && accepts < 2; cyc++) begin
      drive(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      cycle(fi, fo, got, exp);
      if (fi) accepts++;
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      drive(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      cycle(fi, fo, got, exp);
      total++;
      if (fi !== 1'b1 || fo !== 1'b1 || got !== exp ||
          dut.s1_valid !== 1'b1 || dut.s2_valid !== 1'b1) begin
        bad++;
        $display("FAIL simul cyc%0d got in=%b out=%b s1=%b s2=%b %h want 1/1/1/1 %h", cyc, fi,
                 fo, dut.s1_valid, dut.s2_valid, got, exp);
      end
    end
    idle();
    for (int cyc = 0; cyc < 10 && sb.size() > 0; cyc++) begin
      cycle(fi, fo, got, exp);
      if (fo) begin
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL simul_drain got %h want %h", got, exp);
        end
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL simul_timeout got pending=%0d want 0", sb.size());
    end
  endtask

  task automatic test_random();
    logic fi, fo;
    res_t got, exp;
    int sent, cyc;
    sent = 0;
    cyc  = 0;
    while ((sent < 10000 || sb.size() > 0) && cyc < 40000) begin
      if (sent < 10000 && $urandom_range(3) != 0)
        drive(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      else
        idle();
      out_ready = ($urandom_range(3) != 0);
      cycle(fi, fo, got, exp);
      if (fi) sent++;
      if (fo) begin
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL random got %h want %h", got, exp);
        end
      end
      cyc++;
    end
    idle();
    total++;
    if (sent != 10000 || sb.size() != 0) begin
      bad++;
      $display("FAIL random_timeout got sent=%0d pending=%0d want 10000/0", sent, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    logic fi, fo;
    res_t got, exp;
    int accepts, stale;
    accepts   = 0;
    stale     = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 6 && accepts < 2; cyc++) begin
      drive(16'h1234, 16'h4321, 1'b1);
      cycle(fi, fo, got, exp);
      if (fi) accepts++;
    end
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || overflow !== 1'b0 ||
        dut.s1_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid got v=%b s=%h c=%b o=%b s1=%b want 0/0000/0/0/0", out_valid, sum,
               cout, overflow, dut.s1_valid);
    end
    sb.delete();
    @(negedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_ready got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      cycle(fi, fo, got, exp);
      if (fo || out_valid) stale++;
    end
    total++;
    if (stale != 0) begin
      bad++;
      $display("FAIL rst_mid_stale got %0d stale cycles want 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Two-stage pipelined carry-lookahead adder for the execute stage. It sits directly downstream of the 2-input AND/XOR gate level.
- Stage 1 registers the per-bit generate (a AND b) and propagate (a XOR b) terms together with cin.
- Stage 2 resolves the carries with 4-bit group lookahead plus a second-level lookahead across groups, then registers sum, cout and overflow.
- Uses a valid/ready handshake on both sides, so the adder can be stalled by the processor pipeline.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of GROUP, and must be at least 8.
- GROUP, 4, bits per lookahead group. Only 4 is supported.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream presents a, b, cin.
- in_ready  out  1  adder accepts the operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in.
- out_valid  out  1  sum, cout and overflow hold a result.
- out_ready  in  1  downstream consumes the result this cycle.
- sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB.
- overflow  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n low, asynchronous):
  - s1_valid and s2_valid clear to 0.
  - g, p and cin registers clear to 0.
  - sum, cout and overflow clear to 0.
  - in_ready reads 1 once the reset is released.
  - Reset asserted mid-operation discards every in-flight result; nothing is emitted after release.
- Handshake:
  - A transfer occurs in a cycle where valid and ready are both high at a rising edge.
  - Operands are sampled only on an input transfer.
  - out_valid stays high and sum/cout/overflow stay stable until out_ready is high.
- Pipeline advance (combinational):
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv.
  - No combinational path from a, b or cin to any output.
- Stage 1, on an input transfer:
  - g <= a & b, p <= a ^ b, c0 <= cin, s1_valid <= 1.
  - Otherwise, if s1_adv is high, s1_valid <= 0.
  - Otherwise hold all stage-1 registers.
- Stage 2, when s2_adv is high:
  - s2_valid <= s1_valid.
  - If s1_valid is high, load sum = p ^ {carries[WIDTH-1:0]}, cout = c[WIDTH], overflow = c[WIDTH-1] ^ c[WIDTH].
  - When s2_adv is low, hold everything.
- Carry rules:
  - Inside a group: c[i+1] = g[i] | p[i]&c[i], expanded flat, with no ripple between bits.
  - Group terms:
    - GG = g3 | p3g2 | p3p2g1 | p3p2p1g0.
    - GP = p3p2p1p0.
  - Group carries are computed by lookahead over GG/GP from c0.
- Latency and throughput:
  - Latency 2 cycles from input transfer to out_valid, with no stall.
  - Throughput 1 result per cycle when out_ready is held high.
- Full stall:
  - Both stages valid and out_ready low gives in_ready = 0.
  - Held upstream data must not be sampled.
- Simultaneous events:
  - Output transfer and input transfer in the same cycle with both stages full: every stage shifts forward.
  - No bubble is inserted and no result is lost or duplicated.
- Wrap-around: the sum wraps modulo 2^WIDTH, and cout carries the lost bit.
- X handling: a and b are ignored when in_valid is low, so X values there must not propagate into valid results.

Decomposition:
- Shared package cla_pkg holds:
  - localparam CLA_GROUP = 4.
  - The function num_groups(width).
  - A typedef for the group GG/GP pair.
- Sub-module cla_group4 is purely combinational:
  - Inputs: g[3:0], p[3:0], ci.
  - Outputs: c[4:1], GG, GP.
  - Instantiated WIDTH/4 times by generate.
- The group-level lookahead and pipeline registers live in cla_pipe_adder.

Test Plan:
- Basic add: apply reset, then a=0x0003, b=0x0005, cin=0 for one cycle with out_ready=1 → out_valid rises exactly 2 cycles later with sum=0x0008, cout=0, overflow=0.
- Carry across all groups: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, overflow=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, overflow=1.
- Cin and signed overflow: a=0x8000, b=0x8000, cin=1 → sum=0x0001, cout=1, overflow=1. Also sweep 10k random operand pairs against a behavioural a+b+cin model.
- Backpressure: stream 5 operand pairs with out_ready=0 → in_ready drops after 2 accepts, and sum holds the first result. Then release out_ready → the 5 results come out in order, 1 per cycle, with none dropped or duplicated.
- Simultaneous in/out: keep both stages full, then pulse in_valid and out_ready together for 3 cycles → 3 results out and 3 operand pairs in, with s1_valid and s2_valid staying 1.
- Reset mid-operation: assert rst_n=0 asynchronously, between clock edges, with both stages valid → out_valid=0 and sum=0 immediately. After release, in_ready=1 and no stale result appears.
